// File: rtl/bus_receiver.sv
// Serial frame receiver for the one-wire node bus: deframes start/addr/mod/data/crc/stop,
// filters on node address, checks CRC-4 and strobes the accepted payload.
module bus_receiver #(
    parameter int          ADDR_W = 4,
    parameter int          DATA_W = 64,
    parameter logic [3:0]  BCAST  = 4'hF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus,
    input  logic [ADDR_W-1:0] my_addr,
    output logic [DATA_W-1:0] rx_data,
    output logic [1:0]        rx_mod,
    output logic              rx_valid,
    output logic              crc_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int SH_W = ADDR_W + 2 + DATA_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_MOD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CRC  = 3'd4;
    localparam logic [2:0] S_STOP = 3'd5;

    localparam logic [6:0] LAST_ADDR = 7'(ADDR_W - 1);
    localparam logic [6:0] LAST_MOD  = 7'(ADDR_W + 1);
    localparam logic [6:0] LAST_DATA = 7'(SH_W - 1);
    localparam logic [6:0] LAST_CRC  = 7'(SH_W + 3);

    logic [2:0]        state;
    logic [6:0]        cnt;
    logic [3:0]        crc;
    logic [3:0]        crc_rx;
    logic [SH_W-1:0]   shreg;
    logic [ADDR_W-1:0] my_addr_q;
    logic              sbit;
    logic              addr_hit;

    function automatic logic [3:0] crc4_next(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic addr_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] mine);
        return (a == mine) || (a == ADDR_W'(BCAST));
    endfunction

    // Anything that is not a clean 1 (0, X, Z) reads as the idle level
    assign sbit = (bus === 1'b1);

    // my_addr is latched at the start bit, so checking the captured address at STOP
    // gives the same answer as checking it right after the last address bit.
    assign addr_hit = addr_match(shreg[SH_W-1 -: ADDR_W], my_addr_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            crc       <= '0;
            my_addr_q <= '0;
            rx_data   <= '0;
            rx_mod    <= '0;
            rx_valid  <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sbit) begin
                        state     <= S_ADDR;
                        cnt       <= '0;
                        crc       <= '0;
                        my_addr_q <= my_addr;
                        busy      <= 1'b1;
                    end
                end
                S_ADDR: begin
                    crc <= crc4_next(crc, sbit);
                    cnt <= cnt + 7'd1;
                    if (cnt == LAST_ADDR) state <= S_MOD;
                end
                S_MOD: begin
                    crc <= crc4_next(crc, sbit);
                    cnt <= cnt + 7'd1;
                    if (cnt == LAST_MOD) state <= S_DATA;
                end
                S_DATA: begin
                    crc <= crc4_next(crc, sbit);
                    cnt <= cnt + 7'd1;
                    if (cnt == LAST_DATA) state <= S_CRC;
                end
                S_CRC: begin
                    cnt <= cnt + 7'd1;
                    if (cnt == LAST_CRC) state <= S_STOP;
                end
                S_STOP: begin
                    // The stop sample is consumed here and never treated as a start bit
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (addr_hit) begin
                        if (sbit) begin
                            frame_err <= 1'b1;
                        end else if (crc_rx == crc) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shreg[DATA_W-1:0];
                            rx_mod   <= shreg[DATA_W+1:DATA_W];
                        end else begin
                            crc_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Field capture registers carry data only and need no reset
    always_ff @(posedge clock) begin
        if (state == S_ADDR || state == S_MOD || state == S_DATA)
            shreg <= {shreg[SH_W-2:0], sbit};
        if (state == S_CRC)
            crc_rx <= {crc_rx[2:0], sbit};
    end

endmodule

// File: tb/tb_bus_receiver.sv
// Bench for bus_receiver: directed frames plus randomized frames checked against a
// frame-level reference model (polynomial-division CRC, address/stop/CRC outcome rules).
module tb_bus_receiver;

    logic        clock = 1'b0;
    logic        reset;
    logic        bus;
    logic [3:0]  my_addr;
    logic [63:0] rx_data;
    logic [1:0]  rx_mod;
    logic        rx_valid;
    logic        crc_err;
    logic        frame_err;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    logic [63:0] exp_data;
    logic [1:0]  exp_mod;

    bus_receiver #(.ADDR_W(4), .DATA_W(64), .BCAST(4'hF)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .my_addr  (my_addr),
        .rx_data  (rx_data),
        .rx_mod   (rx_mod),
        .rx_valid (rx_valid),
        .crc_err  (crc_err),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Remainder of m(x)*x^4 divided by x^4+x+1
    function automatic logic [3:0] crc_ref(input logic [69:0] m);
        logic [73:0] r;
        r = {m, 4'b0000};
        for (int i = 73; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic send_frame(input logic [3:0] a, input logic [1:0] m, input logic [63:0] d,
                              input logic [3:0] c, input bit s, input bit chg, input string tag);
        logic [75:0] f;
        logic [3:0]  me;
        bit hit, good, ev, ec, ef;
        int stray;
        f     = {1'b1, a, m, d, c, s};
        me    = my_addr;
        hit   = (a == me) || (a == 4'hF);
        good  = (c == crc_ref({a, m, d}));
        ev    = hit && !s && good;
        ec    = hit && !s && !good;
        ef    = hit && s;
        stray = 0;
        for (int i = 0; i < 76; i++) begin
            @(negedge clock);
            bus = f[75 - i];
            if (chg && i == 20) my_addr = 4'($urandom_range(0, 15));
            @(posedge clock);
            #1;
            if (i < 75) begin
                if (busy !== 1'b1) stray++;
                if ((rx_valid | crc_err | frame_err) !== 1'b0) stray++;
            end
        end
        if (ev) begin
            exp_data = d;
            exp_mod  = m;
        end
        chk({tag, "_inframe"}, 64'(stray), 64'd0);
        chk({tag, "_valid"}, 64'(rx_valid), 64'(ev));
        chk({tag, "_crcerr"}, 64'(crc_err), 64'(ec));
        chk({tag, "_frmerr"}, 64'(frame_err), 64'(ef));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_data"}, rx_data, exp_data);
        chk({tag, "_mod"}, 64'(rx_mod), 64'(exp_mod));
    endtask

    task automatic idle(input int n, input string tag);
        int stray;
        stray = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus = ($urandom_range(0, 3) == 0) ? 1'bz : 1'b0;
            @(posedge clock);
            #1;
            if ((busy | rx_valid | crc_err | frame_err) !== 1'b0) stray++;
        end
        chk({tag, "_quiet"}, 64'(stray), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"}, rx_data, 64'd0);
        chk({tag, "_mod"}, 64'(rx_mod), 64'd0);
        chk({tag, "_strobes"}, 64'({rx_valid, crc_err, frame_err}), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic [1:0]  m;
        logic [3:0]  a;
        logic [3:0]  c;
        bit          s;

        reset    = 1'b1;
        bus      = 1'b0;
        my_addr  = 4'd3;
        exp_data = '0;
        exp_mod  = '0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        send_frame(4'd3, 2'd1, 64'd22, 4'h3, 1'b0, 1'b0, "basic");
        idle(2, "post_basic");
        send_frame(4'd3, 2'd1, 64'd22, 4'h2, 1'b0, 1'b0, "badcrc");
        send_frame(4'd5, 2'd1, 64'd99, crc_ref({4'd5, 2'd1, 64'd99}), 1'b0, 1'b0, "other");
        send_frame(4'hF, 2'd2, 64'd77, crc_ref({4'hF, 2'd2, 64'd77}), 1'b0, 1'b0, "bcast");
        send_frame(4'd3, 2'd3, 64'd5, crc_ref({4'd3, 2'd3, 64'd5}), 1'b1, 1'b0, "stoperr");
        send_frame(4'd3, 2'd0, 64'hDEAD_BEEF_0123_4567,
                   crc_ref({4'd3, 2'd0, 64'hDEAD_BEEF_0123_4567}), 1'b0, 1'b0, "after_stop");
        for (int k = 0; k < 2; k++) begin
            d = {$urandom, $urandom};
            m = 2'($urandom_range(0, 3));
            send_frame(4'd3, m, d, crc_ref({4'd3, m, d}), 1'b0, 1'b0, "b2b");
        end
        idle(3, "post_b2b");

        // Abort a frame right after E40
        for (int i = 0; i < 41; i++) begin
            @(negedge clock);
            bus = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clock);
        end
        #1;
        reset = 1'b1;
        #1;
        check_zero("midreset");
        exp_data = '0;
        exp_mod  = '0;
        @(negedge clock);
        bus   = 1'b0;
        reset = 1'b0;
        d = {$urandom, $urandom};
        send_frame(4'd3, 2'd2, d, crc_ref({4'd3, 2'd2, d}), 1'b0, 1'b0, "fresh");

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 2))
                0:       a = my_addr;
                1:       a = 4'hF;
                default: a = 4'($urandom_range(0, 15));
            endcase
            m = 2'($urandom_range(0, 3));
            d = {$urandom, $urandom};
            c = crc_ref({a, m, d});
            if ($urandom_range(0, 4) == 0) c = c ^ 4'($urandom_range(1, 15));
            s = ($urandom_range(0, 5) == 0);
            send_frame(a, m, d, c, s, ($urandom_range(0, 4) == 0), "rand");
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), "rand_gap");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_receiver.md
# bus_receiver

Serial frame receiver for the shared one-wire node bus. Samples `bus` once per `clock`, deframes start/address/mode/data/CRC/stop fields, filters on its own node address, checks CRC-4, and presents the 64-bit payload and 2-bit mode with a one-cycle valid strobe. It is the consuming stage directly downstream of the transmitting `node` on the same bus.

## Interface
- `ADDR_W`, 4: address field width; fixed at 4.
- `DATA_W`, 64: payload width; fixed at 64.
- `BCAST`, 4'hF: broadcast address, accepted by every receiver.
- `clock`  input  1  system clock; one bus bit per rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `bus`  input  1  shared serial line. A sampled value other than 1 (0, X, Z) is treated as 0; idle level is 0.
- `my_addr`  input  4  this receiver's node address; quasi-static.
- `rx_data`  output  64  last accepted payload; holds until the next accepted frame.
- `rx_mod`  output  2  mode field of the last accepted frame.
- `rx_valid`  output  1  one-cycle strobe: `rx_data`/`rx_mod` were just updated.
- `crc_err`  output  1  one-cycle strobe: addressed frame failed its CRC.
- `frame_err`  output  1  one-cycle strobe: addressed frame had a bad stop bit.
- `busy`  output  1  high while a frame is being received (any state except IDLE).

## Operation
- Frame, MSB first, 76 bits: start (1) | addr (4) | mod (2) | data (64) | crc (4) | stop (0).
- CRC-4, polynomial x^4+x+1, init 4'h0, over the 70 addr+mod+data bits, no reflection, no final XOR. Serial update per bit b: fb = c[3]^b; c <= {c[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
- FSM states: IDLE -> ADDR (4 bits) -> MOD (2) -> DATA (64) -> CRC (4) -> STOP (1) -> IDLE. A 7-bit bit counter sequences the fields; a 70-bit shift register captures addr/mod/data.
- IDLE: bus sampled 1 = start bit; go to ADDR, clear CRC register and counter. Bus 0: stay.
- Address match = (captured addr == `my_addr`) or (captured addr == `BCAST`), evaluated after the 4th address bit. Non-matching frames are still tracked through STOP to stay bit-aligned, but raise no strobe and leave `rx_data`/`rx_mod` untouched.
- STOP, matching frame: stop=0 and CRC equal -> load `rx_data`, `rx_mod`, pulse `rx_valid`. Stop=0 and CRC unequal -> pulse `crc_err` only. Stop=1 -> pulse `frame_err` only, regardless of CRC. At most one strobe per frame.
- The STOP sample is never reinterpreted as a start bit; the machine enters IDLE after STOP in all cases.
- `my_addr` changes mid-frame take effect on the next frame.

## Timing
- Reset (asynchronous, any time, including mid-frame): state IDLE, counter 0, CRC 0, `rx_data`=0, `rx_mod`=0, `rx_valid`=`crc_err`=`frame_err`=`busy`=0. The first rising edge after deassert may sample a start bit.
- Edge E0 samples start. Edges E1–E4 addr, E5–E6 mod, E7–E70 data, E71–E74 crc, E75 stop.
- All outputs are registered. Strobes and the `rx_data`/`rx_mod` update become visible after E75 and last exactly one cycle. Latency from the start-bit edge to the strobe is 75 cycles.
- `busy` rises after E0 and falls after E75.
- Back-to-back frames: a start bit sampled at E76 (one cycle after stop) begins the next frame; no gap cycle is required.
- Strobes are never asserted while `busy` is low, except in the cycle immediately after E75.

## Test plan
- Reset, then `my_addr`=3; send addr 3, mod 1, data 64'd22, crc 4'h3, stop 0 -> after E75 `rx_valid`=1 for one cycle, `rx_data`=64'd22, `rx_mod`=1, `crc_err`=`frame_err`=0.
- Same frame with crc 4'h2 -> `crc_err` pulse; `rx_data` keeps its previous value; no `rx_valid`.
- Same frame with addr 5 (CRC recomputed) -> no strobes, `busy` high for 75 cycles. Then addr 4'hF with valid CRC -> `rx_valid`.
- Valid frame with stop=1 -> `frame_err` only. A valid frame starting at the next edge is accepted normally.
- Two valid frames back-to-back (second start at E76) -> two `rx_valid` pulses 76 cycles apart, with correct data for each.
- Assert `reset` at E40 of a frame -> all outputs 0 immediately. Release and send a fresh valid frame -> accepted, with no residue from the aborted frame.
